// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : vram_arbiter
//  Brief   : Shares single-port VRAM between display fetch (fixed priority,
//            fixed latency) and a one-entry CPU valid/ready request port.
//  Rev     : 1.0  initial release
// ============================================================================
module vram_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 1023
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              disp_req_i,
   input  logic [ADDR_W-1:0] disp_addr_i,
   output logic [DATA_W-1:0] disp_data_o,
   input  logic              cpu_valid_i,
   output logic              cpu_ready_o,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_starved_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_CNT = MAX_CNT - ONE_CNT;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PENDING = 2'd1;
   localparam logic [1:0] RESP    = 2'd2;

   logic [1:0]        state;
   logic              hold_we;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_wdata;
   logic [CNT_W-1:0]  wait_cnt;
   logic              pending;

   assign pending     = (state == PENDING);
   assign cpu_ready_o = (state == IDLE);
   assign disp_data_o = ram_rdata_i;

   // Display always wins the port; the held CPU request only fills idle cycles.
   assign ram_en_o    = disp_req_i | pending;
   assign ram_we_o    = ~disp_req_i & pending & hold_we;
   assign ram_addr_o  = disp_req_i ? disp_addr_i : hold_addr;
   assign ram_wdata_o = hold_wdata;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state         <= IDLE;
         hold_we       <= 1'b0;
         hold_addr     <= '0;
         hold_wdata    <= '0;
         wait_cnt      <= '0;
         cpu_rvalid_o  <= 1'b0;
         cpu_rdata_o   <= '0;
         cpu_starved_o <= 1'b0;
      end else begin
         cpu_rvalid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_valid_i) begin
                  hold_we    <= cpu_we_i;
                  hold_addr  <= cpu_addr_i;
                  hold_wdata <= cpu_wdata_i;
                  state      <= PENDING;
               end
            end
            PENDING: begin
               if (disp_req_i) begin
                  if (wait_cnt != MAX_CNT) begin
                     wait_cnt <= wait_cnt + ONE_CNT;
                  end
                  // Sticky flag rises on the same edge the counter reaches MAX_WAIT.
                  if (wait_cnt >= LAST_CNT) begin
                     cpu_starved_o <= 1'b1;
                  end
               end else begin
                  wait_cnt <= '0;
                  state    <= hold_we ? IDLE : RESP;
               end
            end
            RESP: begin
               cpu_rdata_o  <= ram_rdata_i;
               cpu_rvalid_o <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
